// File: rtl/up_pkg.sv
// Shared types and constants for the upload serializer.
//   ser_state_t       : serializer FSM state
//   HW_PER_WORD       : 16-bit halfwords per 64-bit word
//   HEAD_WORD_DEFAULT : default frame-header word
package up_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_t;

   localparam int unsigned HW_PER_WORD = 4;

   localparam logic [63:0] HEAD_WORD_DEFAULT = 64'hEB90_EB90_EB90_EB90;

endpackage

// File: rtl/sync_fifo_64.sv
// Single-clock 64-bit FIFO with show-ahead head output.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset (clears pointers and level)
//   push_i   : write din_i (caller guarantees space, or a same-cycle pop)
//   pop_i    : drop the head word (caller guarantees non-empty)
//   din_i    : write data
//   dout_o   : current head word, valid while !empty_o
//   level_o  : words held
//   full_o   : level_o == DEPTH
//   empty_o  : level_o == 0
module sync_fifo_64 #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [63:0]              din_i,
   output logic [63:0]              dout_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_i, pop_i})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset; validity is tracked by level_q.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;
   assign full_o  = (level_q == FullLvl);
   assign empty_o = (level_q == '0);

endmodule

// File: rtl/up_data_serializer.sv
// Buffers the 64-bit upstream word stream (no backpressure) and serializes each word into
// four 16-bit halfwords, MSB first, on a valid/ready interface. Tracks drops and headers.
//   fifo_rdclk : clock
//   rst_n      : synchronous active-low reset
//   data_valid : up_data qualifier
//   up_data    : 64-bit input word
//   tx_ready   : downstream accepts tx_data this cycle
//   clr_ovf    : clears overflow (a same-cycle drop wins)
//   tx_valid   : tx_data valid
//   tx_data    : current halfword
//   fifo_level : words in FIFO, excluding the word being serialized
//   overflow   : sticky drop flag
//   drop_cnt   : dropped words, saturating
//   frame_cnt  : accepted header words, wrapping
module up_data_serializer
   import up_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter logic [63:0] HEAD_WORD = HEAD_WORD_DEFAULT
) (
   input  logic                     fifo_rdclk,
   input  logic                     rst_n,
   input  logic                     data_valid,
   input  logic [63:0]              up_data,
   input  logic                     tx_ready,
   input  logic                     clr_ovf,
   output logic                     tx_valid,
   output logic [15:0]              tx_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [15:0]              drop_cnt,
   output logic [15:0]              frame_cnt
);

   localparam logic [1:0] LastIdx = 2'(HW_PER_WORD - 1);

   ser_state_t  state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [63:0] sh_q, sh_d;
   logic        overflow_q, overflow_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic        fifo_pop, fifo_push, fifo_full, fifo_empty, drop;
   logic [63:0] fifo_dout;

   // A pop in the same cycle frees a slot, so a push at full is still accepted.
   assign fifo_push = data_valid && (!fifo_full || fifo_pop);
   assign drop      = data_valid && !fifo_push;

   sync_fifo_64 #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (fifo_rdclk),
      .rst_ni  (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (up_data),
      .dout_o  (fifo_dout),
      .level_o (fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               sh_d     = fifo_dout;
               fifo_pop = 1'b1;
               idx_d    = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               if (idx_q != LastIdx) begin
                  idx_d = idx_q + 2'd1;
               end else if (!fifo_empty) begin
                  // Back-to-back load: no idle cycle between words.
                  sh_d     = fifo_dout;
                  fifo_pop = 1'b1;
                  idx_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      overflow_d  = overflow_q;
      drop_cnt_d  = drop_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (clr_ovf) overflow_d = 1'b0;
      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
      if (fifo_push && (up_data == HEAD_WORD)) frame_cnt_d = frame_cnt_q + 16'd1;
   end

   always_ff @(posedge fifo_rdclk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         sh_q        <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_comb begin
      tx_data = '0;
      if (state_q == SEND) begin
         unique case (idx_q)
            2'd0:    tx_data = sh_q[63:48];
            2'd1:    tx_data = sh_q[47:32];
            2'd2:    tx_data = sh_q[31:16];
            default: tx_data = sh_q[15:0];
         endcase
      end
   end

   assign tx_valid  = (state_q == SEND);
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_up_data_serializer.sv
module tb_up_data_serializer;

   localparam int unsigned DEPTH = 16;
   localparam logic [63:0] HEAD  = 64'hEB90_EB90_EB90_EB90;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_valid = 1'b0;
   logic [63:0] up_data = '0;
   logic        tx_ready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic        tx_valid;
   logic [15:0] tx_data;
   logic [4:0]  fifo_level;
   logic        overflow;
   logic [15:0] drop_cnt;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: word queue plus the halfwords still to send from the current word.
   logic [63:0] m_q[$];
   logic [15:0] m_cur[$];
   bit          m_ovf = 1'b0;
   int          m_drop = 0;
   int          m_frame = 0;

   up_data_serializer #(
      .DEPTH     (DEPTH),
      .HEAD_WORD (HEAD)
   ) dut (
      .fifo_rdclk (clk),
      .rst_n      (rst_n),
      .data_valid (data_valid),
      .up_data    (up_data),
      .tx_ready   (tx_ready),
      .clr_ovf    (clr_ovf),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one clock with the currently driven inputs, update the model, compare.
   task automatic tick();
      bit          pop, accept, fire;
      logic [63:0] w;
      logic [15:0] hw;
      if (!rst_n) begin
         m_q.delete();
         m_cur.delete();
         m_ovf   = 1'b0;
         m_drop  = 0;
         m_frame = 0;
      end else begin
         fire   = (m_cur.size() > 0) && tx_ready;
         pop    = (m_q.size() > 0) &&
                  ((m_cur.size() == 0) || ((m_cur.size() == 1) && tx_ready));
         accept = data_valid && ((m_q.size() < DEPTH) || pop);
         if (fire) hw = m_cur.pop_front();
         if (pop) begin
            w = m_q.pop_front();
            m_cur.delete();
            m_cur.push_back(w[63:48]);
            m_cur.push_back(w[47:32]);
            m_cur.push_back(w[31:16]);
            m_cur.push_back(w[15:0]);
         end
         if (accept) begin
            m_q.push_back(up_data);
            if (up_data == HEAD) m_frame = (m_frame + 1) % 65536;
         end
         if (clr_ovf) m_ovf = 1'b0;
         if (data_valid && !accept) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
         end
      end
      @(posedge clk);
      #1;
      check_eq("tx_valid", 64'(tx_valid), 64'(m_cur.size() > 0));
      if (m_cur.size() > 0) check_eq("tx_data", 64'(tx_data), 64'(m_cur[0]));
      check_eq("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      check_eq("frame_cnt", 64'(frame_cnt), 64'(m_frame));
   endtask

   task automatic step(input bit dv, input logic [63:0] d, input bit rdy, input bit clr);
      data_valid = dv;
      up_data    = d;
      tx_ready   = rdy;
      clr_ovf    = clr;
      tick();
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(1'b0, 64'h0, rdy, 1'b0);
   endtask

   initial begin
      // Reset
      rst_n = 1'b0;
      idle(3, 1'b1);
      check_eq("rst_tx_data", 64'(tx_data), 64'h0);
      rst_n = 1'b1;

      // Single word
      step(1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
      idle(8, 1'b1);

      // Three back-to-back words
      step(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b0);
      step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
      step(1'b1, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
      idle(16, 1'b1);

      // Stall and fill: 17 words fit (one in the shift register), the 18th drops
      for (int i = 0; i < 17; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      idle(2, 1'b0);
      step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      check_eq("first_drop", 64'(drop_cnt), 64'd1);

      // Push at full coinciding with a pop at the last halfword
      idle(3, 1'b1);
      idle(1, 1'b0);
      step(1'b1, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
      check_eq("full_pushpop_level", 64'(fifo_level), 64'd16);
      idle(1, 1'b0);

      // Headers and clr_ovf interaction
      idle(80, 1'b1);
      step(1'b0, 64'h0, 1'b1, 1'b1);
      step(1'b1, HEAD, 1'b1, 1'b0);
      step(1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
      step(1'b1, HEAD, 1'b1, 1'b0);
      step(1'b1, 64'h0000_0000_0000_0002, 1'b1, 1'b0);
      idle(20, 1'b1);
      check_eq("frame_two", 64'(frame_cnt), 64'd2);
      for (int i = 0; i < 17; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      step(1'b1, HEAD, 1'b0, 1'b1);
      check_eq("drop_beats_clr", 64'(overflow), 64'd1);
      step(1'b0, 64'h0, 1'b0, 1'b1);
      check_eq("clr_alone", 64'(overflow), 64'd0);

      // Reset mid-word at halfword index 2
      idle(80, 1'b1);
      step(1'b1, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b0);
      idle(3, 1'b1);
      check_eq("pre_rst_hw2", 64'(tx_data), 64'hBBBB);
      rst_n = 1'b0;
      idle(1, 1'b1);
      check_eq("mid_rst_valid", 64'(tx_valid), 64'd0);
      check_eq("mid_rst_data", 64'(tx_data), 64'd0);
      rst_n = 1'b1;
      step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
      idle(8, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] d;
         d = ($urandom_range(7) == 0) ? HEAD : {$urandom, $urandom};
         step(($urandom_range(99) < 35), d, ($urandom_range(99) < 80),
              ($urandom_range(99) < 4));
      end
      idle(100, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/up_data_serializer.md
Name: up_data_serializer

Overview:
- Downstream consumer of the 4-channel poll/merge stage: accepts its 64-bit `data_valid`/`up_data` stream.
- The upstream stream has no backpressure. This block buffers it in a small single-clock FIFO.
- Each 64-bit word is serialized into four 16-bit halfwords, MSB first, for the upload interface (USB/FT-type FIFO), using a valid/ready handshake.
- Counts dropped words and frame headers for debug.

Parameters:
- DEPTH, 16, FIFO depth in 64-bit words; power of 2, ≥4.
- HEAD_WORD, 64'hEB90_EB90_EB90_EB90, frame-header word value counted by `frame_cnt`.

Ports:
- fifo_rdclk  in  1  single clock, same domain as the upstream poll stage
- rst_n  in  1  synchronous, active-low reset
- data_valid  in  1  `up_data` qualifier, one word per cycle max
- up_data  in  64  merged channel data incl. frame headers
- tx_ready  in  1  downstream accepts `tx_data` this cycle
- clr_ovf  in  1  one-cycle pulse, clears `overflow`
- tx_valid  out  1  `tx_data` valid
- tx_data  out  16  current halfword
- fifo_level  out  $clog2(DEPTH)+1  words held in FIFO (excludes word in shift register)
- overflow  out  1  sticky: a word was dropped
- drop_cnt  out  16  dropped-word count, saturating
- frame_cnt  out  16  accepted words equal to HEAD_WORD, wrapping

Behaviour:
- Clock and reset:
  - One clock: `fifo_rdclk`. Reset is synchronous, active-low (`rst_n` sampled on `fifo_rdclk` edge).
  - Reset values: `tx_valid`=0, `tx_data`=0, `fifo_level`=0, `overflow`=0, `drop_cnt`=0, `frame_cnt`=0.
  - Reset clears the FIFO pointers and FSM state (→IDLE, idx=0). Reset mid-transfer abandons the partial word and all buffered words.
- Push rule:
  - `data_valid` is accepted when `fifo_level` < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the word is dropped: `overflow`←1 and `drop_cnt`++ (saturates at 16'hFFFF).
- Pop rule: the FIFO head is popped when the FSM loads the shift register (see below). A simultaneous push and pop leaves `fifo_level` unchanged.
- `frame_cnt` increments only on accepted words with `up_data`==HEAD_WORD. Dropped headers are not counted.
- `clr_ovf`: `overflow`←0 next cycle. If `clr_ovf` and a drop happen in the same cycle, the drop wins (`overflow` stays 1). `clr_ovf` does not clear `drop_cnt`.
- FSM states: IDLE, SEND. Holds a 64-bit shift register `sh` and a 2-bit `idx`.
  - IDLE: `tx_valid`=0. If FIFO non-empty: `sh`←head, pop, idx←0, →SEND.
  - SEND: `tx_valid`=1, `tx_data`=`sh[63-16*idx -: 16]`.
    - On `tx_valid`&&`tx_ready`: if idx<3, idx++.
    - If idx==3 and FIFO non-empty: load next head, pop, idx←0, stay SEND (no bubble between words).
    - If idx==3 and FIFO empty: →IDLE.
    - Without `tx_ready`: `tx_data`/`tx_valid` held stable.
- Latency: `data_valid` sampled at edge N → `fifo_level` updates at N+1 → `tx_valid`=1 with halfword 0 after edge N+2.
- Throughput: one halfword per cycle when `tx_ready` is held high. Sustained input above 1 word per 4 cycles eventually overflows; this is intended and reported via `overflow`/`drop_cnt`.
- Pointer wrap is by natural modulo-DEPTH counters. Full/empty are derived from the `fifo_level` count register, not from pointer comparison.

Decomposition:
- Package `up_pkg`:
  - Typedef `ser_state_t` {IDLE, SEND}.
  - Localparam HW_PER_WORD=4.
  - Default HEAD_WORD constant.
- One sub-module: `sync_fifo_64`
  - Single-clock, DEPTH-parameterized, show-ahead head output.
  - Ports: push, pop, din, dout, level, full, empty.
  - Same clock and reset rules as the top.
- FSM and counters stay in the top.

Test Plan:
1. Reset, then one word 64'h1111_2222_3333_4444 with `tx_ready`=1 → `tx_valid` rises 2 cycles later; `tx_data` = 1111, 2222, 3333, 4444 on consecutive cycles; then `tx_valid`=0 and `fifo_level`=0.
2. Three back-to-back words, `tx_ready`=1 → 12 consecutive halfwords with no bubble; `fifo_level` peaks at 2.
3. `tx_ready` held 0 during a SEND → `tx_data` stable; 17 words pushed with DEPTH=16 → first word in `sh`, 16 in FIFO, `overflow`=0; one more push → `overflow`=1, `drop_cnt`=1.
4. Push at full in the same cycle as a pop (`tx_ready` releases at idx==3) → word accepted, `drop_cnt` unchanged, `fifo_level` stays 16.
5. Push HEAD_WORD ×2 plus data words → `frame_cnt`=2; assert `clr_ovf` while a drop occurs → `overflow` stays 1; `clr_ovf` alone → `overflow`=0, `drop_cnt` retained.
6. `rst_n`=0 for one cycle mid-word (idx=2) → next cycle all outputs at reset values; subsequent push is serialized from halfword 0.
